// File: rtl/cla_pkg.sv
// Shared types and carry-lookahead helper for the multi-precision add/subtract sequencer.
package cla_pkg;

    localparam int SLICE_W = 16;

    typedef logic [SLICE_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Flattened 4-bit lookahead: returns carries out of positions 0..3 given generate/propagate and carry-in.
    function automatic logic [3:0] lookahead4(input logic [3:0] g, input logic [3:0] p, input logic ci);
        logic [3:0] c;
        c[0] = g[0] | (p[0] & ci);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

endpackage

// File: rtl/cla_mp_add_seq_slice.sv
// Combinational 16-bit carry-lookahead adder: four 4-bit groups with a second lookahead level across groups.
module cla16_slice
    import cla_pkg::*;
(
    input  word_t a,
    input  word_t b,
    input  logic  cin,
    output word_t s,
    output logic  cout,
    output logic  c15
);

    word_t            p;
    word_t            g;
    logic [3:0]       grp_p;
    logic [3:0]       grp_g;
    logic [3:0]       grp_c;
    logic [3:0]       grp_tmp;
    logic             grp_cin;
    logic [SLICE_W:0] c;

    // NOTE: every variable gets a default before any conditional or loop, so no latches can be inferred.
    always_comb begin
        p       = a ^ b;
        g       = a & b;
        grp_p   = '0;
        grp_g   = '0;
        grp_tmp = '0;
        for (int k = 0; k < 4; k++) begin
            grp_p[k] = &p[4*k +: 4];
            grp_tmp  = lookahead4(g[4*k +: 4], p[4*k +: 4], 1'b0);
            grp_g[k] = grp_tmp[3];
        end
    end

    always_comb begin
        grp_c   = lookahead4(grp_g, grp_p, cin);
        c       = '0;
        c[0]    = cin;
        grp_cin = cin;
        for (int k = 0; k < 4; k++) begin
            grp_cin        = (k == 0) ? cin : grp_c[k-1];
            c[4*k+1 +: 4]  = lookahead4(g[4*k +: 4], p[4*k +: 4], grp_cin);
        end
    end

    assign s    = p ^ c[SLICE_W-1:0];
    assign cout = c[SLICE_W];
    assign c15  = c[SLICE_W-1];

endmodule

// File: rtl/cla_mp_add_seq.sv
// Multi-precision add/subtract sequencer: streams WORDS 16-bit words LS-first through one shared CLA slice.
module cla_mp_add_seq
    import cla_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       sub,
    input  logic [SLICE_W*WORDS-1:0]   a,
    input  logic [SLICE_W*WORDS-1:0]   b,
    output logic                       ready,
    output logic                       busy,
    output logic                       done,
    output logic [SLICE_W*WORDS-1:0]   sum,
    output logic                       cout,
    output logic                       ovf
);

    localparam int               IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    seq_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             sub_q, sub_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    word_t            a_q   [WORDS];
    word_t            a_d   [WORDS];
    word_t            b_q   [WORDS];
    word_t            b_d   [WORDS];
    word_t            sum_q [WORDS];
    word_t            sum_d [WORDS];
    logic             load;

    word_t slice_a;
    word_t slice_b;
    word_t slice_s;
    logic  slice_cin;
    logic  slice_cout;
    logic  slice_c15;

    assign slice_a   = a_q[idx_q];
    assign slice_b   = b_q[idx_q] ^ {SLICE_W{sub_q}};
    assign slice_cin = (idx_q == '0) ? sub_q : carry_q;

    cla16_slice u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (slice_cin),
        .s    (slice_s),
        .cout (slice_cout),
        .c15  (slice_c15)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        load    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q] = slice_s;
                carry_d      = slice_cout;
                if (idx_q == LAST_IDX) begin
                    // Overflow: carry into the MSB differs from carry out of it.
                    cout_d  = slice_cout;
                    ovf_d   = slice_c15 ^ slice_cout;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                load    = start;
                state_d = start ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            sub_d = sub;
            idx_d = '0;
            for (int i = 0; i < WORDS; i++) begin
                a_d[i] = a[SLICE_W*i +: SLICE_W];
                b_d[i] = b[SLICE_W*i +: SLICE_W];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: operand/result word arrays are reset too; sum must read 0 after reset, not stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            a_q     <= '{default: '0};
            b_q     <= '{default: '0};
            sum_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < WORDS; i++) begin
            sum[SLICE_W*i +: SLICE_W] = sum_q[i];
        end
    end

    assign ready = (state_q == IDLE) || (state_q == DONE);
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign cout  = cout_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_cla_mp_add_seq.sv
// Randomized and directed bench for cla_mp_add_seq (WORDS=4) against a plain-arithmetic reference model.
module tb_cla_mp_add_seq;

    localparam int WORDS  = 4;
    localparam int W      = 16 * WORDS;
    localparam int BUDGET = 20;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    cla_mp_add_seq #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    // Reference: {ovf, cout, sum} from W-bit modular arithmetic and sign rules.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        logic [W:0] r;
        logic       o;
        if (s) begin
            r = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
            o = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
        end else begin
            r = {1'b0, x} + {1'b0, y};
            o = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
        end
        return {o, r};
    endfunction

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] v;
        for (int w = 0; w < WORDS; w++) begin
            case ($urandom_range(0, 4))
                0:       v[16*w +: 16] = 16'h0000;
                1:       v[16*w +: 16] = 16'hFFFF;
                2:       v[16*w +: 16] = 16'h7FFF;
                3:       v[16*w +: 16] = 16'h8000;
                default: v[16*w +: 16] = 16'($urandom);
            endcase
        end
        return v;
    endfunction

    // Drives one operation from IDLE/DONE; lat = edges from acceptance until done is seen (or BUDGET).
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, output int lat);
        @(posedge clk); #1;
        a = x; b = y; sub = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; sub = ~s;
        lat = 0;
        while (done !== 1'b1 && lat < BUDGET) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({ready, busy, done, cout, ovf} !== 5'b10000)
            $display("FAIL reset_flags_in_reset: got %b want 10000", {ready, busy, done, cout, ovf});
        else passed++;
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({ready, busy, done, cout, ovf} !== 5'b10000)
            $display("FAIL reset_flags_after: got %b want 10000", {ready, busy, done, cout, ovf});
        else passed++;
        total++;
        if (sum !== '0) $display("FAIL reset_sum: got %h want 0", sum);
        else passed++;
    endtask

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         s;
        logic [W-1:0] e_sum;
        logic         e_cout;
        logic         e_ovf;
    } vec_t;

    task automatic test_directed();
        vec_t v[6];
        int   lat;
        v[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
        v[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0,                   1'b1, 1'b0};
        v[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        v[3] = '{64'h5,                   64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        v[4] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        v[5] = '{64'h0,                   64'h0, 1'b1, 64'h0,                   1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            do_op(v[i].x, v[i].y, v[i].s, lat);
            total++;
            if (lat !== WORDS) $display("FAIL directed%0d_latency: got %0d want %0d", i, lat, WORDS);
            else passed++;
            total++;
            if (sum !== v[i].e_sum) $display("FAIL directed%0d_sum: got %h want %h", i, sum, v[i].e_sum);
            else passed++;
            total++;
            if ({cout, ovf} !== {v[i].e_cout, v[i].e_ovf})
                $display("FAIL directed%0d_cout_ovf: got %b want %b", i, {cout, ovf}, {v[i].e_cout, v[i].e_ovf});
            else passed++;
            @(posedge clk); #1;
            total++;
            if ({done, ready, busy} !== 3'b010 || sum !== v[i].e_sum)
                $display("FAIL directed%0d_hold_idle: got dnrb=%b sum=%h want 010 sum=%h",
                         i, {done, ready, busy}, sum, v[i].e_sum);
            else passed++;
        end
    endtask

    task automatic test_random();
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         s;
        logic [W+1:0] exp;
        int           lat;
        for (int i = 0; i < 24; i++) begin
            x   = rand_operand();
            y   = rand_operand();
            s   = 1'($urandom);
            exp = model(x, y, s);
            do_op(x, y, s, lat);
            total++;
            if (lat !== WORDS) $display("FAIL random%0d_latency: got %0d want %0d", i, lat, WORDS);
            else passed++;
            total++;
            if ({ovf, cout, sum} !== exp)
                $display("FAIL random%0d_result: a=%h b=%h sub=%b got ovf/cout/sum=%b/%b/%h want %b/%b/%h",
                         i, x, y, s, ovf, cout, sum, exp[W+1], exp[W], exp[W-1:0]);
            else passed++;
        end
    endtask

    task automatic test_ignore_start();
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W+1:0] exp;
        int           lat;
        x   = rand_operand();
        y   = rand_operand();
        exp = model(x, y, 1'b0);
        @(posedge clk); #1;
        a = x; b = y; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = ~x; b = ~y; sub = 1'b1; start = 1'b1;
        total++;
        if ({ready, busy} !== 2'b01) $display("FAIL ignore_ready_busy: got %b want 01", {ready, busy});
        else passed++;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < BUDGET) begin
            @(posedge clk); #1;
            lat++;
        end
        total++;
        if (lat !== WORDS) $display("FAIL ignore_latency: got %0d want %0d", lat, WORDS);
        else passed++;
        total++;
        if ({ovf, cout, sum} !== exp)
            $display("FAIL ignore_result: got %b/%b/%h want %b/%b/%h", ovf, cout, sum, exp[W+1], exp[W], exp[W-1:0]);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] xa[4];
        logic [W-1:0] xb[4];
        logic         xs[4];
        logic [W+1:0] exp;
        int           cyc;
        for (int i = 0; i < 4; i++) begin
            xa[i] = rand_operand();
            xb[i] = rand_operand();
            xs[i] = 1'($urandom);
        end
        @(posedge clk); #1;
        a = xa[0]; b = xb[0]; sub = xs[0]; start = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            cyc = 0;
            while (done !== 1'b1 && cyc < BUDGET) begin
                a = {$urandom, $urandom}; b = {$urandom, $urandom}; sub = 1'($urandom);
                @(posedge clk); #1;
                cyc++;
            end
            exp = model(xa[i], xb[i], xs[i]);
            total++;
            if (cyc !== WORDS) $display("FAIL b2b%0d_interval: got %0d want %0d", i, cyc, WORDS);
            else passed++;
            total++;
            if ({ovf, cout, sum} !== exp)
                $display("FAIL b2b%0d_result: got %b/%b/%h want %b/%b/%h",
                         i, ovf, cout, sum, exp[W+1], exp[W], exp[W-1:0]);
            else passed++;
            if (i < 3) begin
                a = xa[i+1]; b = xb[i+1]; sub = xs[i+1];
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (i < 3) begin
                total++;
                if (busy !== 1'b1) $display("FAIL b2b%0d_restart: got busy=%b want 1", i, busy);
                else passed++;
            end
        end
        total++;
        if ({done, ready} !== 2'b01 || {ovf, cout, sum} !== exp)
            $display("FAIL b2b_final_hold: got dn/rdy=%b result=%h want 01 result=%h",
                     {done, ready}, {ovf, cout, sum}, exp);
        else passed++;
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W+1:0] exp;
        int           lat;
        @(posedge clk); #1;
        a = '1; b = '1; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        total++;
        if ({ready, busy, done, cout, ovf} !== 5'b10000 || sum !== '0)
            $display("FAIL midrun_async_reset: got flags=%b sum=%h want 10000 sum=0",
                     {ready, busy, done, cout, ovf}, sum);
        else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (WORDS + 1) @(posedge clk);
        #1;
        total++;
        if ({ready, busy, done} !== 3'b100) $display("FAIL midrun_no_done: got %b want 100", {ready, busy, done});
        else passed++;
        x   = 64'h0000_0000_0000_0001;
        y   = 64'h0000_0000_0000_0001;
        exp = model(x, y, 1'b0);
        do_op(x, y, 1'b0, lat);
        total++;
        if (lat !== WORDS || {ovf, cout, sum} !== exp)
            $display("FAIL midrun_fresh_op: got lat=%0d result=%h want lat=%0d result=%h",
                     lat, {ovf, cout, sum}, WORDS, exp);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
